// File: rtl/pcm_capture_wb.sv
// pcm_capture_wb: multi-channel signed PCM frame capture with optional
// decimation, a frame FIFO, per-channel latest/peak tracking and sticky
// overflow/underflow flags. Everything is read over a Wishbone slave slot.
//
// Ports:
//   clk        system clock (clk_24m domain)
//   rst        synchronous active-high reset
//   pcm_valid  one-cycle strobe, frame on pcm_in valid
//   pcm_in     frame; channel c at [c*SAMPLE_W +: SAMPLE_W]
//   wb_addr    word address
//   wb_wdata   write data
//   wb_we      write enable
//   wb_cyc     cycle/select
//   wb_rdata   registered read data, 0 when not acking a read
//   wb_ack     acknowledge (every access takes 2 cycles)
//   irq        enabled and FIFO level >= nonzero threshold (registered)
module pcm_capture_wb #(
  parameter int CHANNELS        = 2,
  parameter int SAMPLE_W        = 16,
  parameter int FIFO_DEPTH_LOG2 = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pcm_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] pcm_in,
  input  logic [3:0]                   wb_addr,
  input  logic [31:0]                  wb_wdata,
  input  logic                         wb_we,
  input  logic                         wb_cyc,
  output logic [31:0]                  wb_rdata,
  output logic                         wb_ack,
  output logic                         irq
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int FW    = CHANNELS * SAMPLE_W;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;

  logic [FW-1:0]              mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              level;
  logic                       enable;
  logic [7:0]                 decim, dcnt;
  logic [8:0]                 thresh;
  logic                       ovf, udf;
  logic [1:0]                 idx;
  logic [SAMPLE_W-1:0]        peak   [CHANNELS];
  logic [SAMPLE_W-1:0]        latest [CHANNELS];

  logic                acc, wr_acc, rd_acc, clear_now;
  logic                empty, full, cap, accept, pop_req, pop, push;
  logic [SAMPLE_W-1:0] smp   [CHANNELS];
  logic [SAMPLE_W-1:0] abs_s [CHANNELS];
  logic [SAMPLE_W-1:0] head_s;
  logic [31:0]         rd_val;
  logic                unused_wdata;

  assign unused_wdata = ^{wb_wdata[31:25], wb_wdata[7:2]};

  // Side effects happen on the edge where ack is raised.
  assign acc       = wb_cyc && !wb_ack;
  assign wr_acc    = acc && wb_we;
  assign rd_acc    = acc && !wb_we;
  assign clear_now = wr_acc && (wb_addr == 4'd0) && wb_wdata[1];
  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign cap       = pcm_valid && enable && !clear_now;
  assign accept    = cap && (dcnt == '0);
  assign pop_req   = rd_acc && (wb_addr == 4'd2);
  assign pop       = pop_req && !empty && (idx == 2'(CHANNELS - 1));
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push      = accept && (!full || pop);

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      smp[c] = pcm_in[c*SAMPLE_W +: SAMPLE_W];
      if (!smp[c][SAMPLE_W-1])
        abs_s[c] = smp[c];
      else if (smp[c] == {1'b1, {(SAMPLE_W-1){1'b0}}})
        abs_s[c] = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else
        abs_s[c] = -smp[c];
    end
  end

  always_comb begin
    head_s = '0;
    rd_val = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      if (32'(idx) == c) head_s = mem[rd_ptr][c*SAMPLE_W +: SAMPLE_W];
    case (wb_addr)
      4'd0: rd_val = {7'd0, thresh, decim, 7'd0, enable};
      4'd1: rd_val = {12'd0, udf, ovf, full, empty, 6'd0, 10'(level)};
      4'd2: if (!empty) rd_val = {{(32-SAMPLE_W){head_s[SAMPLE_W-1]}}, head_s};
      default: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (wb_addr == 4'(4 + c)) rd_val = 32'(peak[c]);
          if (wb_addr == 4'(8 + c))
            rd_val = {{(32-SAMPLE_W){latest[c][SAMPLE_W-1]}}, latest[c]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pcm_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
      irq      <= 1'b0;
      enable   <= 1'b0;
      decim    <= '0;
      thresh   <= '0;
      dcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      idx      <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        peak[c]   <= '0;
        latest[c] <= '0;
      end
    end else begin
      wb_ack   <= acc;
      wb_rdata <= rd_acc ? rd_val : '0;
      irq      <= enable && (thresh != '0) && (10'(level) >= 10'(thresh));

      if (wr_acc && wb_addr == 4'd0) begin
        enable <= wb_wdata[0];
        decim  <= wb_wdata[15:8];
        thresh <= wb_wdata[24:16];
      end

      if (clear_now)
        dcnt <= '0;
      else if (cap)
        dcnt <= (dcnt == '0) ? decim : dcnt - 8'd1;

      if (clear_now) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        idx    <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
        if (pop_req && !empty) idx <= pop ? 2'd0 : idx + 2'd1;
        // Flag clear by write first, so a same-cycle event still sets it.
        if (wr_acc && wb_addr == 4'd1 && wb_wdata[18]) ovf <= 1'b0;
        if (wr_acc && wb_addr == 4'd1 && wb_wdata[19]) udf <= 1'b0;
        if (accept && full && !pop) ovf <= 1'b1;
        if (pop_req && empty)       udf <= 1'b1;
      end

      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (accept) begin
          latest[c] <= smp[c];
          if ((wr_acc && wb_addr == 4'(4 + c)) || abs_s[c] > peak[c])
            peak[c] <= abs_s[c];
        end else if (wr_acc && wb_addr == 4'(4 + c)) begin
          peak[c] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_capture_wb.sv
// Self-checking bench for pcm_capture_wb (default parameters: 2 channels,
// 16-bit samples, 64-frame FIFO).
module tb_pcm_capture_wb;

  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pcm_valid;
  logic [FW-1:0] pcm_in;
  logic [3:0]    wb_addr;
  logic [31:0]   wb_wdata;
  logic          wb_we;
  logic          wb_cyc;
  logic [31:0]   wb_rdata;
  logic          wb_ack;
  logic          irq;

  int checks = 0;
  int errors = 0;

  pcm_capture_wb #(
    .CHANNELS(2),
    .SAMPLE_W(16),
    .FIFO_DEPTH_LOG2(6)
  ) dut (
    .clk(clk), .rst(rst), .pcm_valid(pcm_valid), .pcm_in(pcm_in),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_rdata(wb_rdata), .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_PUSH} op_t;
  typedef struct {
    op_t         op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One Wishbone access, optionally with a pcm_valid strobe landing on the
  // same edge as the access side effects.
  task automatic wb_acc(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic pv, input logic [FW-1:0] frame, output logic [31:0] rd);
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdata;
    pcm_valid = pv;
    if (pv) pcm_in = frame;
    @(negedge clk);
    chk("ack", {31'd0, wb_ack}, 32'd1);
    rd = wb_rdata;
    wb_cyc = 1'b0; wb_we = 1'b0; pcm_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    wb_acc(1'b1, addr, wdata, 1'b0, '0, rd);
  endtask

  task automatic wb_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    wb_acc(1'b0, addr, '0, 1'b0, '0, rd);
    chk(name, rd, exp);
  endtask

  task automatic push(input logic [FW-1:0] frame);
    @(negedge clk);
    pcm_valid = 1'b1; pcm_in = frame;
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{OP_WR,   4'd0, 32'h0000_0001, 32'h0,          "ctrl_en"};
    vecs[1]  = '{OP_PUSH, 4'd0, 32'hFFFE_1234, 32'h0,          "push0"};
    vecs[2]  = '{OP_PUSH, 4'd0, 32'h8000_0001, 32'h0,          "push1"};
    vecs[3]  = '{OP_PUSH, 4'd0, 32'h0000_7FFF, 32'h0,          "push2"};
    vecs[4]  = '{OP_RD,   4'd1, 32'h0,         32'h0000_0003,  "status_level3"};
    vecs[5]  = '{OP_RD,   4'd2, 32'h0,         32'h0000_1234,  "data0"};
    vecs[6]  = '{OP_RD,   4'd2, 32'h0,         32'hFFFF_FFFE,  "data1"};
    vecs[7]  = '{OP_RD,   4'd2, 32'h0,         32'h0000_0001,  "data2"};
    vecs[8]  = '{OP_RD,   4'd2, 32'h0,         32'hFFFF_8000,  "data3"};
    vecs[9]  = '{OP_RD,   4'd2, 32'h0,         32'h0000_7FFF,  "data4"};
    vecs[10] = '{OP_RD,   4'd2, 32'h0,         32'h0000_0000,  "data5"};
    vecs[11] = '{OP_RD,   4'd1, 32'h0,         32'h0001_0000,  "status_empty"};

    rst = 1'b1; pcm_valid = 1'b0; pcm_in = '0;
    wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ack",   {31'd0, wb_ack}, 32'd0);
    chk("rst_rdata", wb_rdata,        32'd0);
    chk("rst_irq",   {31'd0, irq},    32'd0);
    wb_read(4'd0, 32'h0000_0000, "rst_ctrl");
    wb_read(4'd1, 32'h0001_0000, "rst_status");
    wb_read(4'd4, 32'h0000_0000, "rst_peak0");
    @(negedge clk);
    chk("rdata_idle", wb_rdata, 32'd0);

    // Basic capture and readout
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:   wb_write(vecs[i].addr, vecs[i].data);
        OP_PUSH: push(vecs[i].data);
        default: wb_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
      endcase
    end

    // Overflow: 65 frames into a 64-deep FIFO
    for (int i = 0; i < 65; i++) push({16'h8000 | 16'(i), 16'h0100 + 16'(i)});
    wb_read(4'd1, 32'h0006_0040, "ovf_status");
    wb_read(4'd2, 32'h0000_0100, "ovf_pop_ch0");
    wb_read(4'd2, 32'hFFFF_8000, "ovf_pop_ch1");
    wb_write(4'd1, 32'h0004_0000);
    wb_read(4'd1, 32'h0000_003F, "ovf_cleared");
    wb_write(4'd0, 32'h0000_0003);
    wb_read(4'd1, 32'h0001_0000, "clear_empty");

    // Underflow
    wb_read(4'd2, 32'h0000_0000, "udf_data");
    wb_read(4'd1, 32'h0009_0000, "udf_status");
    wb_write(4'd1, 32'h0008_0000);
    wb_read(4'd1, 32'h0001_0000, "udf_cleared");

    // Decimation 1-in-4, with a disabled gap that must not advance the count
    wb_write(4'd0, 32'h0000_0301);
    for (int i = 0; i < 6; i++) push({16'h0, 16'h0010 + 16'(i)});
    wb_write(4'd0, 32'h0000_0300);
    push(32'h0000_00AA);
    push(32'h0000_00BB);
    wb_write(4'd0, 32'h0000_0301);
    for (int i = 6; i < 12; i++) push({16'h0, 16'h0010 + 16'(i)});
    wb_read(4'd1, 32'h0000_0003, "dec_level");
    wb_read(4'd8, 32'h0000_0018, "dec_latest0");
    wb_read(4'd6, 32'h0000_0000, "unmapped_peak2");
    wb_read(4'd2, 32'h0000_0010, "dec_f0");
    wb_read(4'd2, 32'h0000_0000, "dec_f0_ch1");
    wb_read(4'd2, 32'h0000_0014, "dec_f4");
    wb_read(4'd2, 32'h0000_0000, "dec_f4_ch1");
    wb_read(4'd2, 32'h0000_0018, "dec_f8");
    wb_read(4'd2, 32'h0000_0000, "dec_f8_ch1");
    wb_write(4'd0, 32'h0000_0001);

    // Peak hold and saturation of the most negative sample
    wb_write(4'd4, 32'h0000_0000);
    wb_read(4'd4, 32'h0000_0000, "peak_clr0");
    push(32'h0000_0100);
    wb_read(4'd4, 32'h0000_0100, "peak_pos");
    push(32'h0000_FF00);
    wb_read(4'd4, 32'h0000_0100, "peak_neg");
    push(32'h0000_8000);
    wb_read(4'd4, 32'h0000_7FFF, "peak_sat");
    wb_read(4'd8, 32'hFFFF_8000, "latest_neg");
    wb_write(4'd4, 32'h1234_5678);
    wb_read(4'd4, 32'h0000_0000, "peak_wclr");
    wb_write(4'd0, 32'h0000_0003);

    // Push and pop on the same edge while full
    for (int i = 0; i < 64; i++) push({16'h0300 + 16'(i), 16'h0200 + 16'(i)});
    wb_read(4'd1, 32'h0002_0040, "full_status");
    wb_read(4'd2, 32'h0000_0200, "sim_ch0");
    wb_acc(1'b0, 4'd2, '0, 1'b1, 32'h0A0A_0A0A, rd);
    chk("sim_ch1", rd, 32'h0000_0300);
    wb_read(4'd1, 32'h0002_0040, "sim_status");

    // irq with threshold 2, one cycle behind the level
    wb_write(4'd0, 32'h0002_0003);
    chk("irq_after_clr", {31'd0, irq}, 32'd0);
    push(32'h0000_0001);
    @(negedge clk);
    chk("irq_level1", {31'd0, irq}, 32'd0);
    push(32'h0000_0002);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wb_write(4'd0, 32'h0002_0003);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_drop", {31'd0, irq}, 32'd0);

    // Frame arriving on the clear edge is discarded
    wb_acc(1'b1, 4'd0, 32'h0000_0003, 1'b1, 32'h5555_5555, rd);
    wb_read(4'd1, 32'h0001_0000, "clr_discard");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pcm_capture_wb.md
Name: pcm_capture_wb

Overview:
- Parametrised successor to the single-shot DAC debug registers.
- Captures multi-channel signed PCM frames, qualified by a valid strobe (e.g. ym3016 output), into a FIFO. Optional decimation is applied before the FIFO.
- Tracks per-channel latest sample, absolute peak hold and overflow/underflow status.
- The CPU reads everything over the SoC Wishbone bus as one peripheral slot.

Parameters:
- CHANNELS, 2, number of PCM channels per frame (1..4)
- SAMPLE_W, 16, bits per sample, signed two's complement (8..24)
- FIFO_DEPTH_LOG2, 6, FIFO depth is 2^FIFO_DEPTH_LOG2 frames (2..9)

Ports:
- clk  in  1  system clock (clk_24m domain)
- rst  in  1  synchronous active-high reset
- pcm_valid  in  1  one-cycle strobe, frame on pcm_in valid
- pcm_in  in  CHANNELS*SAMPLE_W  frame; channel c at [c*SAMPLE_W +: SAMPLE_W]
- wb_addr  in  4  word address
- wb_wdata  in  32  write data
- wb_we  in  1  write enable
- wb_cyc  in  1  cycle/select
- wb_rdata  out  32  read data, 0 when not acking a read
- wb_ack  out  1  acknowledge
- irq  out  1  level: enabled and FIFO level >= threshold

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; ctrl = 0; flags = 0; peaks = 0; latest = 0.
  - Channel read index = 0; decimation counter = 0.
- Wishbone:
  - wb_ack <= wb_cyc && !wb_ack. Every access completes in exactly 2 cycles; accesses are never stalled.
  - wb_rdata is registered with the ack; it is 0 for writes and for unmapped addresses.
  - Side effects (pop, clear) fire exactly once per access, in the cycle ack is asserted.
- Register map (word addresses):
  - 0 CTRL (RW):
    - [0] enable
    - [1] clear (self-clearing, reads 0)
    - [15:8] decim (capture 1 of every decim+1 frames)
    - [24:16] irq threshold
  - 1 STATUS (RO):
    - [9:0] level
    - [16] empty
    - [17] full
    - [18] overflow
    - [19] underflow
    - Writing 1 to [18]/[19] at addr 1 clears the corresponding flag.
  - 2 DATA (RO, pop):
    - Returns channel idx of the head frame, sign-extended to 32 bits; idx then increments.
    - On the read of channel CHANNELS-1, the head is popped and idx wraps to 0.
  - 4+c PEAK[c] (R, write any value clears), for c < CHANNELS: unsigned abs peak.
  - 8+c LATEST[c] (RO), for c < CHANNELS: last accepted sample, sign-extended.
  - Addresses for c >= CHANNELS read 0.
- Capture:
  - When pcm_valid && enable:
    - If decim counter == 0: frame accepted and counter <= decim.
    - Else: counter decrements and the frame is dropped.
  - pcm_valid while disabled is ignored and the counter is unchanged.
- Accepted frame:
  - Pushed if not full. If full, the frame is dropped, overflow is set sticky, and FIFO contents are unchanged.
  - LATEST and PEAK update regardless of full.
- Peak:
  - abs(s) is computed in SAMPLE_W bits. -2^(SAMPLE_W-1) saturates to 2^(SAMPLE_W-1)-1.
  - peak <= max(peak, abs). A PEAK clear-write and an update in the same cycle resolve to abs (the new sample wins).
- DATA read when empty: returns 0, no pointer or idx change, underflow set sticky.
- Push and pop in the same cycle: both occur and level is unchanged.
  - A push while full and a pop in the same cycle: the push is accepted, level stays full, and overflow is not set.
- FIFO:
  - Circular, pointers wrap at 2^FIFO_DEPTH_LOG2.
  - level = count 0..2^FIFO_DEPTH_LOG2; full when level == depth.
  - Read latency of head data is hidden by the 2-cycle access.
- Clear write (CTRL[1]=1):
  - Empties the FIFO and resets idx and the decim counter. Overflow/underflow are cleared.
  - Peaks and latest are kept.
  - The other CTRL fields in the same write still take effect.
  - A concurrent pcm_valid in the clear cycle is discarded.
- irq = enable && (level >= threshold) && (threshold != 0), registered (1-cycle lag after a level change).
- rst mid-access: wb_ack drops next cycle and all state returns to reset values.

Test Plan:
- Defaults, enable=1, decim=0: three frames L/R = (0x1234,0xFFFE), (0x0001,0x8000), (0x7FFF,0x0000).
  - Expect level=3.
  - Six DATA reads return 0x00001234, 0xFFFFFFFE, 0x00000001, 0xFFFF8000, 0x00007FFF, 0x00000000.
  - Expect empty=1 after the sixth read.
- Overflow: 65 frames with no reads.
  - Expect level=64, full=1, overflow=1.
  - First pop returns frame 0.
  - Write 0x40000 to STATUS and expect overflow=0.
- Underflow: DATA read when empty.
  - Expect rdata=0 and underflow=1; level stays 0.
- Decimation: decim=3, 12 frames numbered 0..11.
  - Expect level=3 holding frames 0, 4, 8.
  - pcm_valid while enable=0 is not counted.
- Peak: samples 0x0100, 0xFF00, 0x8000 on ch0.
  - PEAK[0] reads 0x100, then 0x100, then 0x7FFF.
  - Write PEAK[0] and expect 0.
- Simultaneous events:
  - Pop and push in the same cycle at level 64 keeps level=64 with no overflow.
  - threshold=2 raises irq one cycle after the second push.
  - Clear drops irq.
